// File: rtl/switch_control_xy.sv
// Routing/arbitration controller for one Phoenix router: round-robin header arbitration,
// XY routing (west-first adaptive when SWITCH_CONTROL_WEST_FIRST_EN is defined), crossbar allocation.
//
// state   | meaning
// S_IDLE  | wait for any header request
// S_ARB   | round-robin pick of the requesting input
// S_ROUTE | compute output port from the header destination
// S_GRANT | allocate the output, flag a U-turn, or drop back to retry
// S_ACK   | close the one-cycle header acknowledge
module switch_control_xy #(
  parameter int FLIT_W = 16,
  parameter int ADDR_W = 4,
  parameter int XL     = 0,
  parameter int YL     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            h,
  input  logic [5*FLIT_W-1:0]   data,
  input  logic [4:0]            sender,
  output logic [4:0]            ack_h,
  output logic [4:0]            free,
  output logic [14:0]           mux_in,
  output logic [14:0]           mux_out,
  output logic                  route_err
);

  localparam logic [2:0] P_EAST  = 3'd0;
  localparam logic [2:0] P_WEST  = 3'd1;
  localparam logic [2:0] P_NORTH = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_LOCAL = 3'd4;

  localparam logic [ADDR_W-1:0] X_LOC = ADDR_W'(XL);
  localparam logic [ADDR_W-1:0] Y_LOC = ADDR_W'(YL);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT, S_ACK} state_t;

  state_t      state, state_n;
  logic [2:0]  rr, rr_n;
  logic [2:0]  sel, sel_n;
  logic [2:0]  dir, dir_n;
  logic [4:0]  sender_q;
  logic [4:0]  free_n;
  logic [14:0] mux_in_n, mux_out_n;
  logic [4:0]  ack_n;
  logic        err_n;

  logic [FLIT_W-1:0] hdr;
  logic [ADDR_W-1:0] dx, dy;
  logic [2:0]        route_dir;
  logic              unused_hdr_bits;

  always_comb begin
    hdr = '0;
    for (int i = 0; i < 5; i++)
      if (sel == 3'(i)) hdr = data[i*FLIT_W +: FLIT_W];
  end

  assign dx = hdr[2*ADDR_W-1:ADDR_W];
  assign dy = hdr[ADDR_W-1:0];
  assign unused_hdr_bits = ^hdr[FLIT_W-1:2*ADDR_W];

`ifdef SWITCH_CONTROL_WEST_FIRST_EN
  logic [4:0] prod, avail;
  always_comb begin
    prod      = '0;
    avail     = '0;
    route_dir = P_LOCAL;
    if (dx < X_LOC) begin
      route_dir = P_WEST;
    end else begin
      prod[P_EAST]  = (dx > X_LOC);
      prod[P_NORTH] = (dy > Y_LOC);
      prod[P_SOUTH] = (dy < Y_LOC);
      avail = prod & free;
      // Descending scan so the lowest-index candidate wins; busy-only sets still block and retry.
      for (int i = 4; i >= 0; i--) begin
        if (avail != '0) begin
          if (avail[i]) route_dir = 3'(i);
        end else if (prod[i]) begin
          route_dir = 3'(i);
        end
      end
    end
  end
`else
  always_comb begin
    if (dx > X_LOC)      route_dir = P_EAST;
    else if (dx < X_LOC) route_dir = P_WEST;
    else if (dy > Y_LOC) route_dir = P_NORTH;
    else if (dy < Y_LOC) route_dir = P_SOUTH;
    else                 route_dir = P_LOCAL;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      rr        <= P_LOCAL;
      sel       <= '0;
      dir       <= '0;
      sender_q  <= '0;
      free      <= 5'b11111;
      mux_in    <= '0;
      mux_out   <= '0;
      ack_h     <= '0;
      route_err <= 1'b0;
    end else begin
      state     <= state_n;
      rr        <= rr_n;
      sel       <= sel_n;
      dir       <= dir_n;
      sender_q  <= sender;
      free      <= free_n;
      mux_in    <= mux_in_n;
      mux_out   <= mux_out_n;
      ack_h     <= ack_n;
      route_err <= err_n;
    end
  end

  always_comb begin
    logic found;
    int   idx;
    state_n   = state;
    rr_n      = rr;
    sel_n     = sel;
    dir_n     = dir;
    free_n    = free;
    mux_in_n  = mux_in;
    mux_out_n = mux_out;
    ack_n     = '0;
    err_n     = 1'b0;
    found     = 1'b0;
    idx       = 0;

    case (state)
      S_IDLE: if (|h) state_n = S_ARB;
      S_ARB: begin
        for (int k = 1; k <= 5; k++) begin
          idx = (int'(rr) + k) % 5;
          if (!found && h[idx]) begin
            found = 1'b1;
            sel_n = 3'(idx);
          end
        end
        // A request withdrawn before arbitration leaves nothing to route.
        if (found) begin
          rr_n    = sel_n;
          state_n = S_ROUTE;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ROUTE: begin
        dir_n   = route_dir;
        state_n = S_GRANT;
      end
      S_GRANT: begin
        if (dir == sel && dir != P_LOCAL) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (free[dir]) begin
          free_n[dir]                     = 1'b0;
          mux_out_n[int'(dir)*3 +: 3]     = sel;
          mux_in_n[int'(sel)*3 +: 3]      = dir;
          ack_n[sel]                      = 1'b1;
          state_n                         = S_ACK;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ACK:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // End-of-packet release runs regardless of FSM state.
    for (int i = 0; i < 5; i++)
      if (sender_q[i] && !sender[i] && mux_in[i*3 +: 3] <= P_LOCAL)
        free_n[mux_in[i*3 +: 3]] = 1'b1;
  end

endmodule

// File: tb/tb_switch_control_xy.sv
// Directed bench for switch_control_xy at XL=YL=1; expectations follow
// SWITCH_CONTROL_WEST_FIRST_EN when the build defines it.
module tb_switch_control_xy;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  h;
  logic [79:0] data;
  logic [4:0]  sender;
  logic [4:0]  ack_h;
  logic [4:0]  free;
  logic [14:0] mux_in;
  logic [14:0] mux_out;
  logic        route_err;

  int checks = 0;
  int errors = 0;

  switch_control_xy #(.FLIT_W(16), .ADDR_W(4), .XL(1), .YL(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .h         (h),
    .data      (data),
    .sender    (sender),
    .ack_h     (ack_h),
    .free      (free),
    .mux_in    (mux_in),
    .mux_out   (mux_out),
    .route_err (route_err)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag, input logic [4:0] want, input int budget);
    logic got;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      step(1);
      if (ack_h == want) got = 1'b1;
    end
    check(tag, 32'(got), 32'd1);
  endtask

  task automatic watch_no_ack(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      step(1);
      if (ack_h != 5'b0) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    h      = '0;
    data   = '0;
    sender = '0;
    step(2);
    check("rst_free", 32'(free), 32'h1f);
    check("rst_ack", 32'(ack_h), 32'h0);
    check("rst_mux_in", 32'(mux_in), 32'h0);
    check("rst_mux_out", 32'(mux_out), 32'h0);
    check("rst_err", 32'(route_err), 32'h0);
    reset = 1'b1;
    step(1);

    // LOCAL header to (3,1) goes EAST, acked exactly 4 clocks later for one cycle
    data[64 +: 16] = 16'h0031;
    h = 5'b10000;
    step(3);
    check("t1_no_early_ack", 32'(ack_h), 32'h0);
    step(1);
    check("t1_ack", 32'(ack_h), 32'h10);
    check("t1_free", 32'(free), 32'h1e);
    check("t1_mux_out0", 32'(mux_out[2:0]), 32'd4);
    check("t1_mux_in4", 32'(mux_in[14:12]), 32'd0);
    h = '0;
    sender[4] = 1'b1;
    step(1);
    check("t1_ack_width", 32'(ack_h), 32'h0);
    sender[4] = 1'b0;
    step(1);
    check("t1_release", 32'(free), 32'h1f);

    // EAST and LOCAL both to NORTH: EAST first, LOCAL blocked until sender[0] falls
    data[0 +: 16]  = 16'h0013;
    data[64 +: 16] = 16'h0013;
    h = 5'b10001;
    step(4);
    check("t2_east_ack", 32'(ack_h), 32'h01);
    check("t2_free", 32'(free), 32'h1b);
    check("t2_mux_out2", 32'(mux_out[8:6]), 32'd0);
    check("t2_mux_in0", 32'(mux_in[2:0]), 32'd2);
    h = 5'b10000;
    sender[0] = 1'b1;
    watch_no_ack("t2_local_blocked", 20);
    check("t2_north_busy", 32'(free[2]), 32'd0);
    sender[0] = 1'b0;
    step(1);
    check("t2_release_edge", 32'(free), 32'h1f);
    wait_ack("t2_local_ack", 5'b10000, 12);
    check("t2_mux_out2_local", 32'(mux_out[8:6]), 32'd4);
    check("t2_mux_in4", 32'(mux_in[14:12]), 32'd2);
    check("t2_free_after", 32'(free), 32'h1b);
    h = '0;
    step(1);
    check("t2_ack_width", 32'(ack_h), 32'h0);
    sender[4] = 1'b1;
    step(1);
    sender[4] = 1'b0;
    step(1);
    check("t2_cleanup", 32'(free), 32'h1f);

    // WEST input routed back WEST: U-turn error pulse, no allocation
    data[16 +: 16] = 16'h0001;
    h = 5'b00010;
    step(4);
    check("t3_err", 32'(route_err), 32'd1);
    check("t3_no_ack", 32'(ack_h), 32'h0);
    check("t3_free", 32'(free), 32'h1f);
    h = '0;
    step(1);
    check("t3_err_width", 32'(route_err), 32'd0);
    step(2);

    // Allocate outputs 0 and 2, then reset while a blocked header sits in S_GRANT
    data[64 +: 16] = 16'h0031;
    h = 5'b10000;
    step(4);
    check("t4_ack_local", 32'(ack_h), 32'h10);
    h = '0;
    sender[4] = 1'b1;
    step(1);
    data[0 +: 16] = 16'h0013;
    h = 5'b00001;
    step(4);
    check("t4_ack_east", 32'(ack_h), 32'h01);
    check("t4_free", 32'(free), 32'h1a);
    h = '0;
    sender[0] = 1'b1;
    step(1);
    data[32 +: 16] = 16'h0031;
    h = 5'b00100;
    step(3);
    reset  = 1'b0;
    h      = '0;
    sender = '0;
    step(1);
    check("t4_rst_free", 32'(free), 32'h1f);
    check("t4_rst_ack", 32'(ack_h), 32'h0);
    check("t4_rst_mux_in", 32'(mux_in), 32'h0);
    check("t4_rst_mux_out", 32'(mux_out), 32'h0);
    reset = 1'b1;
    step(1);

    // EAST busy, SOUTH input to (3,3): west-first takes NORTH, XY waits for EAST
    data[64 +: 16] = 16'h0031;
    h = 5'b10000;
    step(4);
    check("t5_post_rst_ack", 32'(ack_h), 32'h10);
    h = '0;
    sender[4] = 1'b1;
    step(1);
    data[48 +: 16] = 16'h0033;
    h = 5'b01000;
    step(4);
`ifdef SWITCH_CONTROL_WEST_FIRST_EN
    check("t5_wf_ack", 32'(ack_h), 32'h08);
    check("t5_wf_mux_out2", 32'(mux_out[8:6]), 32'd3);
    check("t5_wf_mux_in3", 32'(mux_in[11:9]), 32'd2);
    check("t5_wf_free", 32'(free), 32'h1a);
    h = '0;
`else
    check("t5_xy_no_ack", 32'(ack_h), 32'h0);
    watch_no_ack("t5_xy_blocked", 15);
    sender[4] = 1'b0;
    step(1);
    wait_ack("t5_xy_ack", 5'b01000, 12);
    check("t5_xy_mux_out0", 32'(mux_out[2:0]), 32'd3);
    check("t5_xy_mux_in3", 32'(mux_in[11:9]), 32'd0);
    h = '0;
`endif
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
